// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: port count, default payload width and the
// {valid, data} word layout used by crossbar4x4 and its egress stages.
package xbar_pkg;

    localparam int XBAR_PORTS = 4;
    localparam int XBAR_WIDTH = 8;

    typedef struct packed {
        logic                  valid;
        logic [XBAR_WIDTH-1:0] data;
    } xbar_word_t;

    // The valid flag sits directly above the payload bits.
    function automatic int VALID_BIT(input int w);
        return w;
    endfunction

endpackage

// File: rtl/xbar_egress_fifo.sv
// Show-ahead FIFO for one crossbar egress port: storage, wrapping pointers,
// a separate occupancy register and a registered head-of-queue word.
module xbar_egress_fifo #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [width-1:0]         i_data,
    output logic [width-1:0]         o_data,
    output logic [$clog2(depth):0]   o_count
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [width-1:0] r_data;

    logic [AW-1:0]    w_rd_next;
    logic [CW-1:0]    w_remain;

    assign w_rd_next = r_rd_ptr + AW'(i_pop);
    assign w_remain  = r_count - CW'(i_pop);

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // The head register tracks mem[rd_ptr]; when the incoming word will be the
    // new head it bypasses the array, and with nothing left it simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            if (i_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
            if (i_push && (w_remain == '0))
                r_data <= i_data;
            else if (w_remain != '0)
                r_data <= r_mem[w_rd_next];
        end
    end

    assign o_data  = r_data;
    assign o_count = r_count;

endmodule

// File: rtl/xbar_egress_port.sv
// Egress stage for one crossbar output: accept/drop, almost-full stall and
// statistics. Define XBAR_EGRESS_STATS_EN for pkt_cnt and live drop stats.
module xbar_egress_port
    import xbar_pkg::*;
#(
    parameter int width        = XBAR_WIDTH,
    parameter int depth        = 16,
    parameter int afull_thresh = depth - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [width:0]           in_word,
    output logic                     stall,
    output logic [width-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(depth):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
`ifdef XBAR_EGRESS_STATS_EN
    ,
    output logic [15:0]              pkt_cnt
`endif
);

    localparam int CW = $clog2(depth) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
    localparam logic [CW-1:0] THRESH_C = CW'(afull_thresh);

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_valid = in_word[VALID_BIT(width)];
    assign w_full  = (count == DEPTH_C);
    assign w_pop   = out_valid && out_ready;
    // A full queue still takes a word when the sink frees a slot this cycle.
    assign w_push  = w_valid && (!w_full || w_pop);

    xbar_egress_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (in_word[width-1:0]),
        .o_data  (out_data),
        .o_count (count)
    );

    assign out_valid = (count != '0);
    assign stall     = (count >= THRESH_C);

`ifdef XBAR_EGRESS_STATS_EN
    logic        w_drop;
    logic        r_overflow;
    logic [15:0] r_drop_cnt;
    logic [15:0] r_pkt_cnt;

    assign w_drop = w_valid && !w_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF)
                    r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_pop && (r_pkt_cnt != 16'hFFFF))
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
    assign pkt_cnt  = r_pkt_cnt;
`else
    assign overflow = 1'b0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_xbar_egress_port.sv
// Randomized bench for xbar_egress_port against a queue-based reference
// model; directed sequences cover fill, overflow, full-bypass and reset.
module tb_xbar_egress_port;
    import xbar_pkg::*;

    localparam int W = 8;
    localparam int D = 16;
    localparam int THRESH = D - 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W:0]   in_word;
    logic         stall;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   count;
    logic         overflow;
    logic [15:0]  drop_cnt;
`ifdef XBAR_EGRESS_STATS_EN
    logic [15:0]  pkt_cnt;
`endif

    xbar_egress_port #(
        .width        (W),
        .depth        (D),
        .afull_thresh (THRESH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .stall     (stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`ifdef XBAR_EGRESS_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    byte unsigned mQueue[$];
    int           mDrop;
    bit           mOverflow;
    int           mPkt;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelClear();
        mQueue.delete();
        mDrop     = 0;
        mOverflow = 0;
        mPkt      = 0;
    endtask

    task automatic checkModel();
        checkOutput("out_valid", 32'(out_valid), 32'(mQueue.size() != 0));
        if (mQueue.size() != 0)
            checkOutput("out_data", 32'(out_data), 32'(mQueue[0]));
        checkOutput("count", 32'(count), 32'(mQueue.size()));
        checkOutput("stall", 32'(stall), 32'(mQueue.size() >= THRESH));
`ifdef XBAR_EGRESS_STATS_EN
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrop));
        checkOutput("overflow", 32'(overflow), 32'(mOverflow));
        checkOutput("pkt_cnt", 32'(pkt_cnt), 32'(mPkt));
`else
        checkOutput("drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("overflow", 32'(overflow), 32'd0);
`endif
    endtask

    // Called at a falling edge: check, drive, let one rising edge pass,
    // advance the model by the queue rules, return at the next falling edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
        xbar_word_t w;
        bit pop;
        bit push;
        checkModel();
        w.valid   = v;
        w.data    = v ? d : 8'h00;
        in_word   = w;
        out_ready = r;
        @(posedge clk);
        pop  = (mQueue.size() != 0) && r;
        push = v && ((mQueue.size() < D) || pop);
        if (pop) begin
            void'(mQueue.pop_front());
            if (mPkt < 65535) mPkt++;
        end
        if (push)
            mQueue.push_back(d);
        else if (v) begin
            mOverflow = 1;
            if (mDrop < 65535) mDrop++;
        end
        @(negedge clk);
    endtask

    initial begin
        in_word   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        modelClear();
        #2 rst = 1'b0;
        #10;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single word, presented one cycle after the write
        applyStimulus(1, 8'hAA, 1);
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_data", 32'(out_data), 32'hAA);
        applyStimulus(0, 8'h00, 1);
        checkOutput("t1_count", 32'(count), 32'd0);

        // fill to the almost-full threshold with the sink stalled
        for (int i = 0; i < 14; i++) applyStimulus(1, 8'(i), 0);
        checkOutput("t2_stall", 32'(stall), 32'd1);
        checkOutput("t2_count", 32'(count), 32'd14);

        for (int i = 14; i < 18; i++) applyStimulus(1, 8'(i), 0);
        checkOutput("t3_count", 32'(count), 32'd16);
`ifdef XBAR_EGRESS_STATS_EN
        checkOutput("t3_drop_cnt", 32'(drop_cnt), 32'd2);
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
`endif
        checkOutput("t3_head", 32'(out_data), 32'h00);

        // full queue with a simultaneous pop still takes the new word
        applyStimulus(1, 8'h55, 1);
        checkOutput("t4_count", 32'(count), 32'd16);
        checkOutput("t4_head", 32'(out_data), 32'h01);
        for (int i = 0; i < 16; i++) applyStimulus(0, 8'h00, 1);
        checkOutput("t4_drained", 32'(count), 32'd0);

        // sustained streaming
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, 8'($urandom), 1);
            checkOutput("t5_count_le1", 32'(count <= 5'd1), 32'd1);
        end
        applyStimulus(0, 8'h00, 1);

        // reset mid-operation
        for (int i = 0; i < 7; i++) applyStimulus(1, 8'(8'h70 + i), 0);
        checkOutput("t6_count7", 32'(count), 32'd7);
        #2 rst = 1'b0;
        #1;
        modelClear();
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_out_data", 32'(out_data), 32'd0);
        checkOutput("t6_count", 32'(count), 32'd0);
        checkOutput("t6_stall", 32'(stall), 32'd0);
        checkOutput("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("t6_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 8'hC3, 0);
        checkOutput("t6_first_word", 32'(out_data), 32'hC3);

        // random phases with varying write and drain pressure
        for (int ph = 0; ph < 6; ph++) begin
            int pv;
            int pr;
            pv = 30 + 14 * ph;
            pr = 90 - 14 * ph;
            for (int i = 0; i < 400; i++)
                applyStimulus(($urandom_range(99) < pv), 8'($urandom), ($urandom_range(99) < pr));
        end
        checkModel();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
